i2s_mst_ctrl: RTL and testbench

Master-mode sequencer for the I2S transceiver core. It generates the bit clock (SCK) and word select (WS) that the core consumes on its i2s_sck_i/i2s_ws_i inputs, and emits edge strobes for the core's sampling logic. Start and stop are clean: configuration is latched only at frame boundaries, and on disable the block drains to a frame end before parking the clocks.

---
 rtl/i2s_pkg.sv | 24 ++
 rtl/i2s_clkdiv.sv | 51 +++++
 rtl/i2s_mst_ctrl.sv | 126 ++++++++++++
 tb/tb_i2s_mst_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and channel-length helpers for the I2S master sequencer.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic CHL_16 = 1'b0;
    localparam logic CHL_32 = 1'b1;

    function automatic logic [6:0] chlen(input logic chl);
        return (chl == CHL_32) ? 7'd32 : 7'd16;
    endfunction

    // Index of the last bit in a stereo frame (2*chlen - 1).
    function automatic logic [5:0] last_bit(input logic chl);
        logic [6:0] t;
        t = (chlen(chl) << 1) - 7'd1;
        return t[5:0];
    endfunction

endpackage

// File: rtl/i2s_clkdiv.sv
// SCK half-period divider: toggles sck_o every div_i+1 enabled cycles and
// flags the cycle whose closing clk edge changes sck_o.
module i2s_clkdiv #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 sck_o,
    output logic                 rise_o,
    output logic                 fall_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sck_q, sck_d;
    logic                 hit;

    assign hit    = en_i && !clr_i && (cnt_q == div_i);
    assign rise_o = hit && !sck_q;
    assign fall_o = hit && sck_q;
    assign sck_o  = sck_q;

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (clr_i) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (en_i) begin
            if (hit) begin
                cnt_d = '0;
                sck_d = ~sck_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/i2s_mst_ctrl.sv
// I2S master sequencer: generates SCK/WS, frame strobes and a frame counter,
// latching configuration only at frame boundaries and draining on disable.
module i2s_mst_ctrl
    import i2s_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [DIV_WIDTH-1:0]  div_i,
    input  logic                  chl_i,
    input  logic                  ws_pol_i,
    input  logic                  core_busy_i,
    output logic                  sck_o,
    output logic                  ws_o,
    output logic                  sck_rise_o,
    output logic                  sck_fall_o,
    output logic                  frame_start_o,
    output logic                  busy_o,
    output logic [FCNT_WIDTH-1:0] frame_cnt_o
);

    state_e                state_q, state_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic                  chl_q, chl_d;
    logic                  ws_pol_q, ws_pol_d;
    logic [5:0]            bit_cnt_q, bit_cnt_d;
    logic                  ws_q, ws_d;
    logic [FCNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                  frame_start_q, frame_start_d;
    logic                  div_clr, sck_fall, frame_end;

    // The divider is held cleared in IDLE so SCK always restarts from a fresh low phase.
    assign div_clr = (state_q == ST_IDLE);

    i2s_clkdiv #(.DIV_WIDTH(DIV_WIDTH)) u_clkdiv (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (div_clr),
        .en_i   (!div_clr),
        .div_i  (div_q),
        .sck_o  (sck_o),
        .rise_o (sck_rise_o),
        .fall_o (sck_fall)
    );

    assign frame_end     = sck_fall && (bit_cnt_q == last_bit(chl_q));
    assign sck_fall_o    = sck_fall;
    assign ws_o          = (state_q == ST_IDLE) ? ws_pol_i : ws_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign frame_start_o = frame_start_q;
    assign frame_cnt_o   = frame_cnt_q;

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        chl_d         = chl_q;
        ws_pol_d      = ws_pol_q;
        bit_cnt_d     = bit_cnt_q;
        ws_d          = ws_q;
        frame_cnt_d   = frame_cnt_q;
        frame_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d       = ST_RUN;
                    div_d         = div_i;
                    chl_d         = chl_i;
                    ws_pol_d      = ws_pol_i;
                    bit_cnt_d     = '0;
                    ws_d          = ws_pol_i;
                    frame_start_d = 1'b1;
                end
            end
            default: begin
                if (sck_fall) begin
                    if (frame_end) begin
                        bit_cnt_d     = '0;
                        frame_cnt_d   = frame_cnt_q + 1'b1;
                        div_d         = div_i;
                        chl_d         = chl_i;
                        ws_pol_d      = ws_pol_i;
                        ws_d          = ws_pol_i;
                        frame_start_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        ws_d      = ({1'b0, bit_cnt_d} >= chlen(chl_q)) ^ ws_pol_q;
                    end
                end
                if (state_q == ST_RUN) begin
                    if (!en_i) state_d = ST_DRAIN;
                end else if (en_i) begin
                    state_d = ST_RUN;
                end else if (frame_end && !core_busy_i) begin
                    state_d       = ST_IDLE;
                    frame_start_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            chl_q         <= 1'b0;
            ws_pol_q      <= 1'b0;
            bit_cnt_q     <= '0;
            ws_q          <= 1'b0;
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            chl_q         <= chl_d;
            ws_pol_q      <= ws_pol_d;
            bit_cnt_q     <= bit_cnt_d;
            ws_q          <= ws_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_i2s_mst_ctrl.sv
// Bench for i2s_mst_ctrl: a time-position reference model checked every cycle,
// a table of start configurations, and directed drain/config sequences.
module tb_i2s_mst_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] div = 16'd0;
    logic        chl = 1'b0;
    logic        pol = 1'b0;
    logic        core_busy = 1'b0;
    logic        sck_o, ws_o, sck_rise_o, sck_fall_o, frame_start_o, busy_o;
    logic [15:0] frame_cnt_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;
    logic chk_en = 1'b0;

    i2s_mst_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .div_i         (div),
        .chl_i         (chl),
        .ws_pol_i      (pol),
        .core_busy_i   (core_busy),
        .sck_o         (sck_o),
        .ws_o          (ws_o),
        .sck_rise_o    (sck_rise_o),
        .sck_fall_o    (sck_fall_o),
        .frame_start_o (frame_start_o),
        .busy_o        (busy_o),
        .frame_cnt_o   (frame_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: position m_t (clk cycles into the current frame) with
    // SCK, bit index and WS derived from it by division.
    int m_st = 0;   // 0 idle, 1 run, 2 drain
    int m_t = 0, m_div = 0, m_chl = 0, m_pol = 0, m_fcnt = 0, m_fs = 0;
    int hp, flen;
    bit fend;

    always @(posedge clk) begin
        if (rst) begin
            m_st = 0; m_t = 0; m_div = 0; m_chl = 0; m_pol = 0; m_fcnt = 0; m_fs = 0;
        end else if (m_st == 0) begin
            m_fs = 0;
            if (en) begin
                m_st = 1; m_t = 0; m_div = div; m_chl = chl; m_pol = pol; m_fs = 1;
            end
        end else begin
            hp   = m_div + 1;
            flen = 4 * hp * (m_chl ? 32 : 16);
            fend = (m_t == flen - 1);
            m_t  = fend ? 0 : m_t + 1;
            if (fend) begin
                m_fcnt = (m_fcnt + 1) % 65536;
                m_div = div; m_chl = chl; m_pol = pol;
            end
            m_fs = fend;
            if (m_st == 1) begin
                if (!en) m_st = 2;
            end else if (en) begin
                m_st = 1;
            end else if (fend && !core_busy) begin
                m_st = 0; m_fs = 0;
            end
        end
    end

    always @(negedge clk) begin
        int eh, clen;
        bit run, e_sck, tog;
        logic [21:0] exp_v, act_v;
        if (chk_en) begin
            run  = (m_st != 0);
            eh   = m_div + 1;
            clen = m_chl ? 32 : 16;
            e_sck = run && (((m_t / eh) % 2) == 1);
            tog   = run && (((m_t + 1) % eh) == 0);
            exp_v = {e_sck,
                     run ? ((((m_t / (2 * eh)) >= clen) ? 1'b1 : 1'b0) ^ m_pol[0]) : pol,
                     tog && !e_sck, tog && e_sck, m_fs[0], run, m_fcnt[15:0]};
            act_v = {sck_o, ws_o, sck_rise_o, sck_fall_o, frame_start_o, busy_o, frame_cnt_o};
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL cycle_model t=%0t got sck/ws/rise/fall/fs/busy/fcnt=%b expected %b",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s timed out", name);
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc(); n++;
            if (frame_start_o) return;
        end
        timeout("wait_frame_start");
        n = -1;
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc(); n++;
            if (sck_rise_o) return;
        end
        timeout("wait_sck_rise");
        n = -1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 4000; i++) begin
            cyc(); n++;
            if (!busy_o) return;
        end
        timeout("wait_idle");
        n = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; core_busy = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] div;
        logic        chl;
        logic        pol;
        int          exp_frame;
        int          exp_period;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int n, t0;
        tbl[0] = '{16'd3, 1'b0, 1'b0, 256, 8};
        tbl[1] = '{16'd0, 1'b1, 1'b0, 128, 2};
        tbl[2] = '{16'd1, 1'b0, 1'b1, 128, 4};
        tbl[3] = '{16'd0, 1'b0, 1'b1, 64, 2};
        tbl[4] = '{16'd2, 1'b1, 1'b1, 384, 6};

        cyc();
        chk_en = 1'b1;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            do_reset();
            div = tbl[i].div; chl = tbl[i].chl; pol = tbl[i].pol; en = 1'b1;
            wait_fs(n);
            chk("first_start_latency", n, 1);
            chk("ws_at_frame_start", int'(ws_o), int'(tbl[i].pol));
            wait_fs(n);
            chk("frame_length", n, tbl[i].exp_frame);
            chk("frame_cnt_after_one", int'(frame_cnt_o), 1);
            wait_rise(n);
            wait_rise(n);
            chk("sck_period", n, tbl[i].exp_period);
        end

        // Reset mid-run after one completed frame.
        do_reset();
        pol = 1'b0; div = 16'd3; chl = 1'b0; en = 1'b1;
        repeat (300) cyc();
        chk("pre_reset_fcnt", int'(frame_cnt_o), 1);
        rst = 1'b1; en = 1'b0;
        cyc();
        chk("rst_sck", int'(sck_o), 0);
        chk("rst_ws", int'(ws_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_fcnt", int'(frame_cnt_o), 0);
        rst = 1'b0;

        // Drop enable at bit 10: drains to bit 63, idles right after the last fall.
        do_reset();
        div = 16'd0; chl = 1'b1; pol = 1'b0; en = 1'b1;
        cyc();
        repeat (20) cyc();
        en = 1'b0;
        wait_idle(n);
        chk("drain_cycles", n, 108);
        chk("drain_fcnt", int'(frame_cnt_o), 1);
        chk("drain_sck_low", int'(sck_o), 0);
        repeat (5) cyc();
        chk("idle_stays_low", int'(sck_o), 0);

        // Core busy across the first frame end extends the drain by one frame.
        do_reset();
        div = 16'd0; chl = 1'b0; core_busy = 1'b1; en = 1'b1;
        cyc();
        repeat (10) cyc();
        en = 1'b0;
        wait_fs(n);
        chk("busy_first_end", n, 54);
        core_busy = 1'b0;
        wait_idle(n);
        chk("busy_extra_frame", n, 64);
        chk("busy_fcnt", int'(frame_cnt_o), 2);

        // Mid-frame divider then channel-length change apply only at frame ends.
        do_reset();
        div = 16'd3; chl = 1'b0; en = 1'b1;
        cyc();
        repeat (40) cyc();
        div = 16'd1;
        wait_rise(n);
        wait_rise(n);
        chk("period_before_end", n, 8);
        wait_fs(n);
        t0 = cyc_n;
        wait_rise(n);
        wait_rise(n);
        chk("period_after_end", n, 4);
        chl = 1'b1;
        wait_fs(n);
        chk("frame_new_div", cyc_n - t0, 128);
        t0 = cyc_n;
        wait_fs(n);
        chk("frame_new_chl", cyc_n - t0, 256);

        // Re-enable during drain: no gap and no extra frame start.
        do_reset();
        div = 16'd0; chl = 1'b0; en = 1'b1;
        cyc();
        t0 = cyc_n;
        repeat (40) cyc();
        en = 1'b0;
        repeat (3) cyc();
        chk("drain_busy", int'(busy_o), 1);
        en = 1'b1;
        wait_fs(n);
        chk("reen_frame1", cyc_n - t0, 64);
        t0 = cyc_n;
        wait_fs(n);
        chk("reen_frame2", cyc_n - t0, 64);
        chk("reen_fcnt", int'(frame_cnt_o), 2);

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 149) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0) begin
                div = 16'($urandom_range(0, 3));
                chl = 1'($urandom_range(0, 1));
                pol = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 9) == 0) core_busy = ~core_busy;
            rst = ($urandom_range(0, 1999) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
